// File: rtl/bus_arbiter_pkg.sv
// Shared types, defaults and helpers for the round-robin bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned MAX_MASTERS       = 8;
  localparam int unsigned MAX_IDX_W         = 3;
  localparam int unsigned DEF_NR_MASTERS    = 4;
  localparam int unsigned DEF_BEGIN_TIMEOUT = 16;
  localparam int unsigned DEF_XFER_TIMEOUT  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_KILL  = 2'd3
  } arb_state_e;

  // Binary index of a one-hot vector (OR of set positions, 0 when empty).
  function automatic logic [MAX_IDX_W-1:0] onehot_to_index(input logic [MAX_MASTERS-1:0] onehot);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
      if (onehot[i]) begin
        idx = idx | MAX_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after the pointer, wrapping.
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NR_MASTERS = DEF_NR_MASTERS,
  localparam int unsigned IDX_W     = $clog2(NR_MASTERS)
) (
  input  logic [NR_MASTERS-1:0] i_request,
  input  logic [IDX_W-1:0]      i_rr_pointer,
  output logic                  o_valid,
  output logic [NR_MASTERS-1:0] o_onehot,
  output logic [IDX_W-1:0]      o_index
);

  int unsigned w_cand;

  // Walk the requests in rotated order and keep the first hit.
  always_comb begin
    o_valid  = 1'b0;
    o_onehot = '0;
    w_cand   = 0;
    for (int unsigned i = 0; i < NR_MASTERS; i++) begin
      w_cand = (32'(i_rr_pointer) + i) % NR_MASTERS;
      if (!o_valid && i_request[IDX_W'(w_cand)]) begin
        o_valid                  = 1'b1;
        o_onehot[IDX_W'(w_cand)] = 1'b1;
      end
    end
  end

  assign o_index = IDX_W'(onehot_to_index(MAX_MASTERS'(o_onehot)));

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus with begin timeout.
// Optional bus watchdog (KILL state, forced termination) enabled by BUS_ARB_WATCHDOG_EN.
module bus_arbiter_rr
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NR_MASTERS    = DEF_NR_MASTERS,
  parameter int unsigned BEGIN_TIMEOUT = DEF_BEGIN_TIMEOUT,
  parameter int unsigned XFER_TIMEOUT  = DEF_XFER_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NR_MASTERS-1:0] request,
  output logic [NR_MASTERS-1:0] granted,
  input  logic                  begin_transaction_in,
  input  logic                  end_transaction_in,
  input  logic                  error_in,
  output logic                  end_transaction_out,
  output logic                  error_out,
  output logic                  bus_idle
);

  localparam int unsigned     IDX_W     = $clog2(NR_MASTERS);
  localparam int unsigned     WAIT_W    = $clog2(BEGIN_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_MASTERS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BEGIN_TIMEOUT - 1);

  if (NR_MASTERS < 2 || NR_MASTERS > MAX_MASTERS) begin : g_bad_nr_masters
    $error("bus_arbiter_rr: NR_MASTERS must be 2..8");
  end
  if (BEGIN_TIMEOUT < 2) begin : g_bad_begin_timeout
    $error("bus_arbiter_rr: BEGIN_TIMEOUT must be at least 2");
  end
  if (XFER_TIMEOUT < 2) begin : g_bad_xfer_timeout
    $error("bus_arbiter_rr: XFER_TIMEOUT must be at least 2");
  end

  arb_state_e            r_state, w_state_nxt;
  logic [NR_MASTERS-1:0] r_granted, w_granted_nxt;
  logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]      r_owner, w_owner_nxt;
  logic [WAIT_W-1:0]     r_wait_cnt, w_wait_cnt_nxt;

  logic                  w_pick_valid;
  logic [NR_MASTERS-1:0] w_pick_onehot;
  logic [IDX_W-1:0]      w_pick_index;
  logic [IDX_W-1:0]      w_owner_inc;
  logic                  w_owner_req;
  logic                  w_wait_done;
  logic                  w_term;

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int unsigned     XFER_W    = $clog2(XFER_TIMEOUT) + 1;
  localparam logic [XFER_W-1:0] XFER_LAST = XFER_W'(XFER_TIMEOUT - 1);

  logic [XFER_W-1:0] r_xfer_cnt, w_xfer_cnt_nxt;
  logic              r_end_out, w_end_out_nxt;
  logic              r_err_out, w_err_out_nxt;
  logic              w_xfer_done;

  assign w_xfer_done = (r_xfer_cnt == XFER_LAST);
`endif

  bus_arbiter_rr_pick #(
    .NR_MASTERS (NR_MASTERS)
  ) u_pick (
    .i_request    (request),
    .i_rr_pointer (r_ptr),
    .o_valid      (w_pick_valid),
    .o_onehot     (w_pick_onehot),
    .o_index      (w_pick_index)
  );

  assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + IDX_W'(1);
  assign w_owner_req = request[r_owner];
  assign w_wait_done = (r_wait_cnt == WAIT_LAST);
  assign w_term      = end_transaction_in | error_in;

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_granted  <= '0;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_wait_cnt <= '0;
`ifdef BUS_ARB_WATCHDOG_EN
      r_xfer_cnt <= '0;
      r_end_out  <= 1'b0;
      r_err_out  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_granted  <= w_granted_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
`ifdef BUS_ARB_WATCHDOG_EN
      r_xfer_cnt <= w_xfer_cnt_nxt;
      r_end_out  <= w_end_out_nxt;
      r_err_out  <= w_err_out_nxt;
`endif
    end
  end

  // Next-state decision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (begin_transaction_in) begin
          w_state_nxt = ST_BUSY;
        end else if (!w_owner_req || w_wait_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_term) begin
          w_state_nxt = ST_IDLE;
        end
`ifdef BUS_ARB_WATCHDOG_EN
        else if (w_xfer_done) begin
          w_state_nxt = ST_KILL;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of grant, pointer, owner, counters and watchdog strobes.
  always_comb begin
    w_granted_nxt  = r_granted;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_wait_cnt_nxt = '0;
`ifdef BUS_ARB_WATCHDOG_EN
    w_xfer_cnt_nxt = '0;
    w_end_out_nxt  = 1'b0;
    w_err_out_nxt  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_granted_nxt = w_pick_onehot;
          w_owner_nxt   = w_pick_index;
        end
      end
      ST_GRANT: begin
        if (w_state_nxt == ST_GRANT) begin
          w_wait_cnt_nxt = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + WAIT_W'(1);
        end else if (w_state_nxt == ST_IDLE) begin
          w_granted_nxt = '0;
          w_ptr_nxt     = w_owner_inc;
        end
      end
      ST_BUSY: begin
        if (w_state_nxt != ST_BUSY) begin
          w_granted_nxt = '0;
          w_ptr_nxt     = w_owner_inc;
        end
`ifdef BUS_ARB_WATCHDOG_EN
        if (w_state_nxt == ST_BUSY) begin
          w_xfer_cnt_nxt = (r_xfer_cnt == '1) ? r_xfer_cnt : r_xfer_cnt + XFER_W'(1);
        end
        if (w_state_nxt == ST_KILL) begin
          w_end_out_nxt = 1'b1;
          w_err_out_nxt = 1'b1;
        end
`endif
      end
      default: begin
        w_granted_nxt = '0;
      end
    endcase
  end

  assign granted  = r_granted;
  assign bus_idle = (r_state == ST_IDLE);

`ifdef BUS_ARB_WATCHDOG_EN
  assign end_transaction_out = r_end_out;
  assign error_out           = r_err_out;
`else
  assign end_transaction_out = 1'b0;
  assign error_out           = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench for bus_arbiter_rr (4 masters, BEGIN_TIMEOUT=16, XFER_TIMEOUT=8).
module tb_bus_arbiter_rr;

  logic       clock;
  logic       reset;
  logic [3:0] request;
  logic [3:0] granted;
  logic       begin_t;
  logic       end_t;
  logic       err_t;
  logic       end_out;
  logic       err_out;
  logic       bus_idle;

  int total = 0;
  int bad   = 0;

  bus_arbiter_rr #(
    .NR_MASTERS    (4),
    .BEGIN_TIMEOUT (16),
    .XFER_TIMEOUT  (8)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .request              (request),
    .granted              (granted),
    .begin_transaction_in (begin_t),
    .end_transaction_in   (end_t),
    .error_in             (err_t),
    .end_transaction_out  (end_out),
    .error_out            (err_out),
    .bus_idle             (bus_idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_g;

    reset   = 1'b1;
    request = 4'b0000;
    begin_t = 1'b0;
    end_t   = 1'b0;
    err_t   = 1'b0;
    step();
    step();
    chk("rst_granted", 32'(granted), 32'h0);
    chk("rst_bus_idle", 32'(bus_idle), 32'h1);
    chk("rst_end_out", 32'(end_out), 32'h0);
    chk("rst_err_out", 32'(err_out), 32'h0);

    // zero requests: stay idle
    reset = 1'b0;
    step();
    chk("idle_no_req", 32'(granted), 32'h0);

    // basic grant latency and handover
    request = 4'b0101;
    step();
    chk("t1_grant0", 32'(granted), 32'h1);
    chk("t1_not_idle", 32'(bus_idle), 32'h0);
    begin_t = 1'b1;
    step();
    begin_t = 1'b0;
    step();
    chk("t1_busy_hold", 32'(granted), 32'h1);
    end_t   = 1'b1;
    request = 4'b0100;
    step();
    end_t = 1'b0;
    chk("t1_end_drop", 32'(granted), 32'h0);
    chk("t1_end_idle", 32'(bus_idle), 32'h1);
    step();
    chk("t1_grant2", 32'(granted), 32'h4);
    begin_t = 1'b1;
    step();
    begin_t = 1'b0;
    end_t   = 1'b1;
    request = 4'b0000;
    step();
    end_t = 1'b0;
    step();
    chk("t1_idle_after", 32'(granted), 32'h0);

    // reset pointer, then all masters request continuously
    reset = 1'b1;
    step();
    reset   = 1'b0;
    request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step();
      chk("t2_rr_grant", 32'(granted), 32'(exp_g));
      begin_t = 1'b1;
      step();
      begin_t = 1'b0;
      step();
      end_t = 1'b1;
      step();
      end_t = 1'b0;
      chk("t2_rr_release", 32'(granted), 32'h0);
    end
    request = 4'b0000;
    step();

    // begin timeout on master 2, then master 3 next
    request = 4'b1100;
    step();
    chk("t3_grant2", 32'(granted), 32'h4);
    for (int k = 0; k < 15; k++) begin
      step();
      chk("t3_grant_wait", 32'(granted), 32'h4);
    end
    step();
    chk("t3_timeout_drop", 32'(granted), 32'h0);
    step();
    chk("t3_grant3", 32'(granted), 32'h8);
    request = 4'b0000;
    step();
    chk("t3_req_drop", 32'(granted), 32'h0);
    chk("t3_req_drop_idle", 32'(bus_idle), 32'h1);

    // error termination of master 1, pointer moves to 2
    request = 4'b0010;
    step();
    chk("t4_grant1", 32'(granted), 32'h2);
    begin_t = 1'b1;
    step();
    begin_t = 1'b0;
    err_t   = 1'b1;
    request = 4'b1111;
    step();
    err_t = 1'b0;
    chk("t4_err_drop", 32'(granted), 32'h0);
    chk("t4_err_end_out", 32'(end_out), 32'h0);
    chk("t4_err_err_out", 32'(err_out), 32'h0);
    step();
    chk("t4_next_is_2", 32'(granted), 32'h4);

    // end and error together count as one termination
    begin_t = 1'b1;
    step();
    begin_t = 1'b0;
    end_t   = 1'b1;
    err_t   = 1'b1;
    step();
    end_t = 1'b0;
    err_t = 1'b0;
    chk("t4_both_drop", 32'(granted), 32'h0);
    step();
    chk("t4_next_is_3", 32'(granted), 32'h8);

    // hung transfer: watchdog kill or indefinite hold
    begin_t = 1'b1;
    step();
    begin_t = 1'b0;
`ifdef BUS_ARB_WATCHDOG_EN
    repeat (7) step();
    chk("t5_busy8_hold", 32'(granted), 32'h8);
    chk("t5_busy8_no_kill", 32'(end_out), 32'h0);
    step();
    chk("t5_kill_granted", 32'(granted), 32'h0);
    chk("t5_kill_end_out", 32'(end_out), 32'h1);
    chk("t5_kill_err_out", 32'(err_out), 32'h1);
    step();
    chk("t5_after_end_out", 32'(end_out), 32'h0);
    chk("t5_after_err_out", 32'(err_out), 32'h0);
    chk("t5_after_idle", 32'(bus_idle), 32'h1);
    step();
    chk("t5_next_is_0", 32'(granted), 32'h1);
`else
    repeat (120) step();
    chk("t5_long_hold", 32'(granted), 32'h8);
    chk("t5_long_end_out", 32'(end_out), 32'h0);
    chk("t5_long_err_out", 32'(err_out), 32'h0);
    end_t = 1'b1;
    step();
    end_t = 1'b0;
    chk("t5_end_drop", 32'(granted), 32'h0);
    step();
    chk("t5_next_is_0", 32'(granted), 32'h1);
`endif

    // reset during BUSY
    begin_t = 1'b1;
    step();
    begin_t = 1'b0;
    step();
    chk("t6_busy", 32'(granted), 32'h1);
    reset = 1'b1;
    step();
    chk("t6_rst_granted", 32'(granted), 32'h0);
    chk("t6_rst_idle", 32'(bus_idle), 32'h1);
    chk("t6_rst_end_out", 32'(end_out), 32'h0);
    step();
    chk("t6_rst_hold", 32'(granted), 32'h0);
    reset = 1'b0;
    step();
    chk("t6_regrant", 32'(granted), 32'h1);

    // begin strobe with no grant is ignored
    request = 4'b0000;
    step();
    begin_t = 1'b1;
    step();
    begin_t = 1'b0;
    chk("t7_begin_idle", 32'(bus_idle), 32'h1);
    chk("t7_begin_nogrant", 32'(granted), 32'h0);
    request = 4'b0100;
    step();
    chk("t7_grant2", 32'(granted), 32'h4);
    chk("t7_not_idle", 32'(bus_idle), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
